feature_stream_packer: RTL and testbench

//  Receiving end of the CHIP keypoint output interface. Captures feature records
//  (X, Y, score, 256-bit descriptor) from CHIP's o_* outputs and buffers them in
//  a record FIFO. Serialises each frame onto a 32-bit valid/ready stream as:

---
 rtl/feature_stream_packer.sv | 194 +++++++++++++++++++
 tb/tb_feature_stream_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/feature_stream_packer.sv
// Captures CHIP keypoint records into a small FIFO and serialises each frame as
// a 32-bit valid/ready stream: header, nine words per feature, then a trailer.
module feature_stream_packer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_end,
  input  logic         i_flag,
  input  logic [9:0]   i_coordinate_X,
  input  logic [9:0]   i_coordinate_Y,
  input  logic [7:0]   i_score,
  input  logic [255:0] i_descriptor,
  output logic [31:0]  o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_overflow,
  output logic         o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 284;

  typedef enum logic [1:0] {IDLE, HEAD, FEAT, TRAIL} state_t;

  state_t          state_q, state_d;
  logic [3:0]      widx_q, widx_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_open_q, frame_open_d;
  logic            hdr_pend_q, hdr_pend_d;
  logic            trail_pend_q, trail_pend_d;
  logic [31:0]     trail_word_q, trail_word_d;
  logic            ovf_q, ovf_d;
  logic            drop_rec_q, drop_rec_d;
  logic            rd_valid_q, rd_valid_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fcnt_q, fcnt_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            abort, open_eff, full, do_write, drop, accept, do_pop;
  logic [AW-1:0]   wr_base, rd_base;
  logic [AW:0]     cnt_base, cnt_after_pop;

  logic [RW-1:0]   mem [DEPTH];
  logic [RW-1:0]   rd_rec_q;
  logic [31:0]     feat_word [9];

  // Record layout: {score, X, Y, descriptor}; descriptor goes out MSW first.
  assign feat_word[0] = {4'h1, rd_rec_q[283:276], rd_rec_q[275:266], rd_rec_q[265:256]};
  for (genvar gi = 1; gi < 9; gi++) begin : g_desc
    assign feat_word[gi] = rd_rec_q[255 - 32*(gi-1) -: 32];
  end

  always_comb begin
    abort    = i_start & frame_open_q;
    open_eff = frame_open_q | i_start;
    wr_base  = abort ? '0 : wr_ptr_q;
    rd_base  = abort ? '0 : rd_ptr_q;
    cnt_base = abort ? '0 : fcnt_q;
    full     = (cnt_base == (AW+1)'(DEPTH));
    do_write = i_flag & open_eff & ~full;
    drop     = i_flag & open_eff & full;
    accept   = valid_q & i_ready;

    state_d      = state_q;
    widx_d       = widx_q;
    data_d       = data_q;
    valid_d      = valid_q;
    hdr_pend_d   = hdr_pend_q;
    trail_pend_d = trail_pend_q;
    drop_rec_d   = drop_rec_q;
    do_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        // A start this cycle may flush the FIFO, so wait for its header first.
        if (!i_start) begin
          if (hdr_pend_q) begin
            state_d    = HEAD;
            data_d     = 32'd0;
            valid_d    = 1'b1;
            hdr_pend_d = 1'b0;
          end else if (rd_valid_q) begin
            state_d = FEAT;
            widx_d  = 4'd0;
            data_d  = feat_word[0];
            valid_d = 1'b1;
          end else if (trail_pend_q && fcnt_q == '0) begin
            state_d      = TRAIL;
            data_d       = trail_word_q;
            valid_d      = 1'b1;
            trail_pend_d = 1'b0;
          end
        end
      end
      HEAD, TRAIL: begin
        if (accept) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      FEAT: begin
        if (accept) begin
          if (widx_q == 4'd8 || abort || drop_rec_q) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            drop_rec_d = 1'b0;
            do_pop     = (widx_q == 4'd8) && !abort && !drop_rec_q;
          end else begin
            widx_d = widx_q + 4'd1;
            data_d = feat_word[widx_q + 4'd1];
          end
        end else if (abort) begin
          // Finish only the word already on the bus; the rest of the record is gone.
          drop_rec_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_after_pop = cnt_base - (AW+1)'(do_pop);
    rd_ptr_d      = rd_base + AW'(do_pop);
    wr_ptr_d      = wr_base + AW'(do_write);
    fcnt_d        = cnt_after_pop + (AW+1)'(do_write);
    // Head entry is readable next cycle only if it was written before this edge.
    rd_valid_d    = (cnt_after_pop != '0);

    count_d = i_start ? '0 : count_q;
    if (do_write && count_d != '1) count_d = count_d + CNTW'(1);
    ovf_d = (i_start ? 1'b0 : ovf_q) | drop;

    frame_open_d = frame_open_q;
    if (i_start) begin
      frame_open_d = 1'b1;
      hdr_pend_d   = 1'b1;
    end
    if (abort) trail_pend_d = 1'b0;
    trail_word_d = trail_word_q;
    if (i_end && open_eff) begin
      frame_open_d = 1'b0;
      trail_pend_d = 1'b1;
      trail_word_d = {4'hE, ovf_d, 11'd0, 16'(count_d)};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      widx_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_open_q <= 1'b0;
      hdr_pend_q   <= 1'b0;
      trail_pend_q <= 1'b0;
      trail_word_q <= '0;
      ovf_q        <= 1'b0;
      drop_rec_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_open_q <= frame_open_d;
      hdr_pend_q   <= hdr_pend_d;
      trail_pend_q <= trail_pend_d;
      trail_word_q <= trail_word_d;
      ovf_q        <= ovf_d;
      drop_rec_q   <= drop_rec_d;
      rd_valid_q   <= rd_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_write) mem[wr_base] <= {i_score, i_coordinate_X, i_coordinate_Y, i_descriptor};
    rd_rec_q <= mem[rd_ptr_d];
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_busy     = frame_open_q | (fcnt_q != '0) | hdr_pend_q | trail_pend_q | valid_q;

endmodule

// File: tb/tb_feature_stream_packer.sv
// Directed bench for feature_stream_packer: frames, backpressure, overflow,
// simultaneous events, mid-frame restart and asynchronous reset.
module tb_feature_stream_packer;
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, fin = 1'b0, flag = 1'b0;
  logic [9:0]   cx = '0, cy = '0;
  logic [7:0]   sc = '0;
  logic [255:0] desc = '0;
  logic         ready = 1'b0;
  logic [31:0]  o_data;
  logic         o_valid, o_overflow, o_busy;

  int           ready_mode = 0;
  logic         ready_man  = 1'b0;
  int           n_vec = 0, n_err = 0;
  logic [31:0]  got_q[$];
  logic [31:0]  exp_q[$];

  feature_stream_packer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_end(fin), .i_flag(flag),
    .i_coordinate_X(cx), .i_coordinate_Y(cy), .i_score(sc), .i_descriptor(desc),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] rx(input int k); return 10'(37*k + 5); endfunction
  function automatic logic [9:0] ry(input int k); return 10'(1000 - 13*k); endfunction
  function automatic logic [7:0] rs(input int k); return 8'(16*k + 3); endfunction
  function automatic logic [255:0] rdesc(input int k);
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[255-32*j -: 32] = 32'hC0DE_0000 | 32'(k*256 + j);
    return d;
  endfunction
  function automatic logic [31:0] rec_word(input int k, input int j);
    logic [255:0] d;
    d = rdesc(k);
    if (j == 0) return {4'h1, rs(k), rx(k), ry(k)};
    return d[255-32*(j-1) -: 32];
  endfunction

  task automatic exp_rec(input int k);
    for (int j = 0; j < 9; j++) exp_q.push_back(rec_word(k, j));
  endtask
  task automatic drive_rec(input int k);
    cx = rx(k); cy = ry(k); sc = rs(k); desc = rdesc(k);
  endtask
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic pulse_start();
    cyc(); start = 1'b1; cyc(); start = 1'b0;
  endtask
  task automatic feed(input int k0, input int n);
    for (int i = 0; i < n; i++) begin cyc(); drive_rec(k0 + i); flag = 1'b1; end
    cyc(); flag = 1'b0;
  endtask
  task automatic end_frame();
    cyc(); fin = 1'b1; cyc(); fin = 1'b0;
  endtask
  task automatic pulse_ready(input int n);
    cyc(); ready_man = 1'b1;
    repeat (n) @(posedge clk);
    #1 ready_man = 1'b0;
  endtask

  task automatic finish_stream(input string name);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin cyc(); t++; end
    repeat (30) cyc();
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Ready driver: moves 2ns after each edge so stimulus at +1ns is seen the same cycle.
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = ready_man;
    endcase
  end

  // Capture accepted words and check that a stalled word is held.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall) begin
        check("hold_data", o_data, prev_data);
        check("hold_valid", 32'(o_valid), 32'd1);
      end
      if (rst_n && o_valid && ready) got_q.push_back(o_data);
      prev_stall = rst_n && o_valid && !ready;
      prev_data  = o_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_data", o_data, 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    cyc(); rst_n = 1'b1;
    ready_mode = 1;
    repeat (3) cyc();

    // 1: two features, ready held high, with latency checks
    exp_q.push_back(32'h0000_0000); exp_rec(0); exp_rec(1); exp_q.push_back(32'hE000_0002);
    pulse_start();
    @(negedge clk); check("t1_hdr_lat0", 32'(o_valid), 32'd0);
    @(negedge clk); check("t1_hdr_lat1", 32'(o_valid), 32'd1);
    check("t1_hdr", o_data, 32'd0);
    repeat (3) cyc();
    cyc(); drive_rec(0); flag = 1'b1;
    cyc(); drive_rec(1);
    @(negedge clk); check("t1_w0_lat1", 32'(o_valid), 32'd0);
    cyc(); flag = 1'b0; fin = 1'b1;
    @(negedge clk); check("t1_w0_lat2", 32'(o_valid), 32'd0);
    cyc(); fin = 1'b0;
    @(negedge clk); check("t1_w0_lat3", 32'(o_valid), 32'd1);
    check("t1_w0", o_data, 32'h1030_17E8);
    finish_stream("t1");

    // 2: same frame under random backpressure
    ready_mode = 2;
    exp_q.push_back(32'h0000_0000); exp_rec(0); exp_rec(1); exp_q.push_back(32'hE000_0002);
    pulse_start(); feed(0, 2); end_frame();
    finish_stream("t2");

    // 3: six records into a four-deep FIFO while stalled
    ready_mode = 0;
    repeat (2) cyc();
    exp_q.push_back(32'h0000_0000);
    for (int k = 2; k < 6; k++) exp_rec(k);
    exp_q.push_back(32'hE800_0004);
    pulse_start(); feed(2, 6); end_frame();
    @(negedge clk);
    check("t3_ovf", 32'(o_overflow), 32'd1);
    check("t3_busy", 32'(o_busy), 32'd1);
    check("t3_hdr_held", o_data, 32'd0);
    ready_mode = 1;
    finish_stream("t3");
    check("t3_ovf_sticky", 32'(o_overflow), 32'd1);

    // 4: flag together with end, then a flag outside any frame
    exp_q.push_back(32'h0000_0000); exp_rec(8); exp_q.push_back(32'hE000_0001);
    pulse_start();
    @(negedge clk); check("t4_ovf_clr", 32'(o_overflow), 32'd0);
    repeat (3) cyc();
    cyc(); drive_rec(8); flag = 1'b1; fin = 1'b1;
    cyc(); flag = 1'b0; fin = 1'b0;
    repeat (4) cyc();
    cyc(); drive_rec(9); flag = 1'b1;
    cyc(); flag = 1'b0;
    finish_stream("t4");

    // 5: restart mid-frame while word 2 of the first record is on the bus
    ready_man = 1'b0; ready_mode = 3;
    repeat (2) cyc();
    exp_q.push_back(32'h0000_0000);
    for (int j = 0; j < 3; j++) exp_q.push_back(rec_word(10, j));
    exp_q.push_back(32'h0000_0000); exp_rec(13); exp_q.push_back(32'hE000_0001);
    pulse_start(); feed(10, 3); repeat (3) cyc();
    pulse_ready(4);
    repeat (2) cyc();
    @(negedge clk);
    check("t5_inflight", o_data, rec_word(10, 2));
    check("t5_inflight_v", 32'(o_valid), 32'd1);
    pulse_start(); feed(13, 1); end_frame();
    ready_mode = 1;
    finish_stream("t5");

    // 6: asynchronous reset in the middle of a record
    pulse_start(); feed(11, 2);
    t = 0;
    while (!(o_valid && o_data[31:28] == 4'h1) && t < 200) begin @(negedge clk); t++; end
    check("t6_midrec", 32'(o_valid && o_data[31:28] == 4'h1), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("t6_rst_data", o_data, 32'd0);
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_ovf", 32'(o_overflow), 32'd0);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(32'h0000_0000); exp_rec(14); exp_q.push_back(32'hE000_0001);
    repeat (2) cyc();
    pulse_start(); feed(14, 1); end_frame();
    finish_stream("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
